// File: rtl/cam_pkg.sv
// Shared constants and state encodings for the camera capture path.
// Frame geometry, address width and the capture/strobe state types live here.
package cam_pkg;

    localparam int unsigned LCD_WIDTH    = 320;
    localparam int unsigned LCD_HEIGHT   = 240;
    localparam int unsigned FRAME_PIXELS = LCD_WIDTH * LCD_HEIGHT;
    localparam int unsigned IDX_W        = 17;

    typedef enum logic [1:0] {
        WAIT_VSYNC = 2'd0,
        WAIT_FRAME = 2'd1,
        BYTE_HI    = 2'd2,
        BYTE_LO    = 2'd3
    } cam_state_e;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_HIGH = 2'd1,
        SEQ_LOW  = 2'd2
    } seq_state_e;

    function automatic logic [15:0] rgb565_pack(input logic [7:0] hi_i, input logic [7:0] lo_i);
        return {hi_i, lo_i};
    endfunction

endpackage

// File: rtl/cam_input_sync.sv
// Brings the camera pins into the clk domain and derives one-cycle edge strobes.
// Data travels through the same flop chain as pclk so a byte is aligned with its edge.
module cam_input_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cam_pclk_i,
    input  logic       cam_vsync_i,
    input  logic       cam_href_i,
    input  logic [7:0] cam_data_i,
    output logic       vsync_o,
    output logic       href_o,
    output logic [7:0] data_o,
    output logic       pclk_rise_o,
    output logic       vsync_rise_o,
    output logic       vsync_fall_o,
    output logic       href_fall_o
);

    localparam int unsigned SYNC_W = 11;

    logic [SYNC_W-1:0] sync_q [SYNC_STAGES];
    logic [SYNC_W-1:0] last_s;
    logic              pclk_prev_q;
    logic              vsync_prev_q;
    logic              href_prev_q;

    // Synchronizer chain plus previous-value flops for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= '0;
            end
            pclk_prev_q  <= 1'b0;
            vsync_prev_q <= 1'b0;
            href_prev_q  <= 1'b0;
        end else begin
            sync_q[0] <= {cam_pclk_i, cam_vsync_i, cam_href_i, cam_data_i};
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            pclk_prev_q  <= last_s[10];
            vsync_prev_q <= last_s[9];
            href_prev_q  <= last_s[8];
        end
    end

    assign last_s       = sync_q[SYNC_STAGES-1];
    assign vsync_o      = last_s[9];
    assign href_o       = last_s[8];
    assign data_o       = last_s[7:0];
    assign pclk_rise_o  = last_s[10] & ~pclk_prev_q;
    assign vsync_rise_o = last_s[9] & ~vsync_prev_q;
    assign vsync_fall_o = ~last_s[9] & vsync_prev_q;
    assign href_fall_o  = ~last_s[8] & href_prev_q;

endmodule

// File: rtl/camera_capture_writer.sv
// Assembles RGB565 pixels from the camera byte stream and writes them to a frame
// buffer through a one-entry holding register and a fixed-length write strobe.
module camera_capture_writer #(
    parameter int unsigned FRAME_PIXELS = cam_pkg::FRAME_PIXELS,
    parameter int unsigned STROBE_LEN   = 4,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cam_pclk,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_data,
    output logic [15:0] w_data,
    output logic        w_en,
    output logic [16:0] w_bufferIndex,
    output logic        frame_done,
    output logic        overrun,
    output logic        overflow
);
    import cam_pkg::*;

    localparam int unsigned          CNT_W    = (STROBE_LEN > 1) ? $clog2(STROBE_LEN) : 1;
    localparam logic [CNT_W-1:0]     CNT_LOAD = CNT_W'(STROBE_LEN - 1);
    localparam logic [IDX_W-1:0]     IDX_MAX  = IDX_W'(FRAME_PIXELS);

    logic       vsync_s, href_s, pclk_rise_s, vsync_rise_s, vsync_fall_s, href_fall_s;
    logic [7:0] data_s;
    logic       pix_done_s;
    logic       seq_load_s;

    cam_state_e       state_q, state_d;
    logic [7:0]       hi_q, hi_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             hold_full_q, hold_full_d;
    logic [15:0]      hold_data_q, hold_data_d;
    logic [IDX_W-1:0] hold_idx_q, hold_idx_d;
    logic             overrun_q, overrun_d;
    logic             overflow_q, overflow_d;
    logic             frame_done_q, frame_done_d;
    seq_state_e       seq_q, seq_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             w_en_q, w_en_d;
    logic [15:0]      w_data_q, w_data_d;
    logic [IDX_W-1:0] w_idx_q, w_idx_d;

    cam_input_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk          (clk),
        .rst          (rst),
        .cam_pclk_i   (cam_pclk),
        .cam_vsync_i  (cam_vsync),
        .cam_href_i   (cam_href),
        .cam_data_i   (cam_data),
        .vsync_o      (vsync_s),
        .href_o       (href_s),
        .data_o       (data_s),
        .pclk_rise_o  (pclk_rise_s),
        .vsync_rise_o (vsync_rise_s),
        .vsync_fall_o (vsync_fall_s),
        .href_fall_o  (href_fall_s)
    );

    // Capture FSM, pixel index and holding register next-state
    always_comb begin
        state_d      = state_q;
        hi_d         = hi_q;
        idx_d        = idx_q;
        overrun_d    = overrun_q;
        overflow_d   = overflow_q;
        frame_done_d = 1'b0;
        pix_done_s   = 1'b0;
        hold_full_d  = hold_full_q & ~seq_load_s;
        hold_data_d  = hold_data_q;
        hold_idx_d   = hold_idx_q;
        case (state_q)
            WAIT_VSYNC: begin
                if (vsync_s) state_d = WAIT_FRAME;
                else         state_d = WAIT_VSYNC;
            end
            WAIT_FRAME: begin
                if (vsync_fall_s) begin
                    idx_d      = '0;
                    overrun_d  = 1'b0;
                    overflow_d = 1'b0;
                    state_d    = BYTE_HI;
                end else begin
                    state_d = WAIT_FRAME;
                end
            end
            BYTE_HI: begin
                if (vsync_rise_s) begin
                    frame_done_d = 1'b1;
                    state_d      = WAIT_FRAME;
                end else if (pclk_rise_s && href_s) begin
                    hi_d    = data_s;
                    state_d = BYTE_LO;
                end else begin
                    state_d = BYTE_HI;
                end
            end
            BYTE_LO: begin
                // A line ending mid-pixel throws the high byte away
                if (vsync_rise_s) begin
                    frame_done_d = 1'b1;
                    state_d      = WAIT_FRAME;
                end else if (href_fall_s) begin
                    state_d = BYTE_HI;
                end else if (pclk_rise_s && href_s) begin
                    pix_done_s = 1'b1;
                    state_d    = BYTE_HI;
                end else begin
                    state_d = BYTE_LO;
                end
            end
            default: state_d = WAIT_VSYNC;
        endcase

        // Index saturates at the frame size; past it every pixel is dropped
        if (pix_done_s) begin
            if (idx_q >= IDX_MAX) begin
                overflow_d = 1'b1;
            end else begin
                idx_d = idx_q + IDX_W'(1);
                if (hold_full_d) begin
                    overrun_d = 1'b1;
                end else begin
                    hold_full_d = 1'b1;
                    hold_data_d = rgb565_pack(hi_q, data_s);
                    hold_idx_d  = idx_q;
                end
            end
        end else begin
            idx_d = idx_d;
        end
    end

    // Strobe sequencer: w_en high STROBE_LEN clks, then low STROBE_LEN clks
    always_comb begin
        seq_d      = seq_q;
        cnt_d      = cnt_q;
        w_en_d     = w_en_q;
        w_data_d   = w_data_q;
        w_idx_d    = w_idx_q;
        seq_load_s = 1'b0;
        case (seq_q)
            SEQ_IDLE: seq_load_s = hold_full_q;
            SEQ_HIGH: begin
                if (cnt_q == '0) begin
                    w_en_d = 1'b0;
                    cnt_d  = CNT_LOAD;
                    seq_d  = SEQ_LOW;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            SEQ_LOW: begin
                if (cnt_q == '0) begin
                    seq_load_s = hold_full_q;
                    seq_d      = SEQ_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: seq_d = SEQ_IDLE;
        endcase
        if (seq_load_s) begin
            w_en_d   = 1'b1;
            w_data_d = hold_data_q;
            w_idx_d  = hold_idx_q;
            cnt_d    = CNT_LOAD;
            seq_d    = SEQ_HIGH;
        end else begin
            w_data_d = w_data_d;
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= WAIT_VSYNC;
            hi_q         <= 8'h00;
            idx_q        <= '0;
            hold_full_q  <= 1'b0;
            hold_data_q  <= 16'h0000;
            hold_idx_q   <= '0;
            overrun_q    <= 1'b0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
            seq_q        <= SEQ_IDLE;
            cnt_q        <= '0;
            w_en_q       <= 1'b0;
            w_data_q     <= 16'h0000;
            w_idx_q      <= '0;
        end else begin
            state_q      <= state_d;
            hi_q         <= hi_d;
            idx_q        <= idx_d;
            hold_full_q  <= hold_full_d;
            hold_data_q  <= hold_data_d;
            hold_idx_q   <= hold_idx_d;
            overrun_q    <= overrun_d;
            overflow_q   <= overflow_d;
            frame_done_q <= frame_done_d;
            seq_q        <= seq_d;
            cnt_q        <= cnt_d;
            w_en_q       <= w_en_d;
            w_data_q     <= w_data_d;
            w_idx_q      <= w_idx_d;
        end
    end

    assign w_data        = w_data_q;
    assign w_en          = w_en_q;
    assign w_bufferIndex = w_idx_q;
    assign frame_done    = frame_done_q;
    assign overrun       = overrun_q;
    assign overflow      = overflow_q;

endmodule

// File: doc/camera_capture_writer.md
CAMERA_CAPTURE_WRITER -- requirements
Module: camera_capture_writer

Interface
REQ-001 SHALL have parameter FRAME_PIXELS, default 76800, pixels per frame (320x240).
REQ-002 SHALL have parameter STROBE_LEN, default 4, clk cycles w_en is held high and the minimum cycles it is held low.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth for camera inputs.
REQ-004 SHALL have port clk  input  1  system clock; the block uses this one clock only.
REQ-005 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-006 SHALL have port cam_pclk  input  1  camera pixel clock, sampled as data.
REQ-007 SHALL have port cam_vsync  input  1  camera frame sync; high = vertical blanking.
REQ-008 SHALL have port cam_href  input  1  camera line valid.
REQ-009 SHALL have port cam_data  input  8  camera byte bus.
REQ-010 SHALL have port w_data  output  16  RGB565 pixel to the frame buffer.
REQ-011 SHALL have port w_en  output  1  write strobe; the frame buffer writes on its rising edge.
REQ-012 SHALL have port w_bufferIndex  output  17  linear pixel address, 0..FRAME_PIXELS-1.
REQ-013 SHALL have port frame_done  output  1  one-clk pulse at the end of each captured frame.
REQ-014 SHALL have port overrun  output  1  sticky flag: pixel dropped because the holding register was full.
REQ-015 SHALL have port overflow  output  1  sticky flag: more than FRAME_PIXELS pixels arrived in a frame.

Function
REQ-016 SHALL pass cam_pclk, cam_vsync, cam_href and cam_data through SYNC_STAGES flops, then detect the cam_pclk rising edge as one-clk pclk_rise.
REQ-017 SHALL implement FSM states WAIT_VSYNC, WAIT_FRAME, BYTE_HI and BYTE_LO.
- WAIT_VSYNC: waits for synced vsync high.
- WAIT_FRAME: waits for vsync falling edge; on it, index is cleared to 0 and the state goes to BYTE_HI.
REQ-018 SHALL capture bytes only on pclk_rise with href high:
- BYTE_HI: latch byte as pixel[15:8], go to BYTE_LO.
- BYTE_LO: form pixel {hi, byte}, go to BYTE_HI.
REQ-019 SHALL return to BYTE_HI on an href falling edge while in BYTE_LO, discarding the half pixel, with index unchanged.
REQ-020 SHALL, on vsync rising edge in BYTE_HI or BYTE_LO:
- pulse frame_done for one clk;
- go to WAIT_FRAME;
- let any pending strobe complete.
REQ-021 SHALL place a completed pixel and its address in a one-entry holding register; the index increments by 1 after each completed pixel.
REQ-022 SHALL run a strobe sequencer: when idle and the holding register is full:
- load w_data and w_bufferIndex from holding;
- drive w_en high for STROBE_LEN clks, then low for STROBE_LEN clks;
- return to idle.
REQ-023 SHALL hold w_data and w_bufferIndex stable from strobe load until the next strobe load.
REQ-024 SHALL, if a pixel completes while the holding register is still full: drop the pixel, still advance the index, and set overrun.
REQ-025 SHALL, for pixels completing with index equal to FRAME_PIXELS: drop them, set overflow, and keep the index saturated at FRAME_PIXELS.
REQ-026 SHALL capture a pixel that completes in the same clk the sequencer empties the holding register, with no drop and no overrun.
REQ-027 SHALL clear overrun and overflow at each vsync falling edge that starts a frame.
REQ-028 SHALL have a minimum pixel-to-pixel write latency of SYNC_STAGES+2 clks from the pclk edge carrying the low byte to the w_en rise.

Reset
REQ-029 SHALL, while rst is high, force: state WAIT_VSYNC; w_en 0; w_data 0; w_bufferIndex 0; frame_done 0; overrun 0; overflow 0; holding register empty; synchronizers 0.
REQ-030 SHALL, on reset mid-frame, write nothing until a full vsync high-then-low sequence is observed.

Structure
REQ-031 SHALL take FRAME_PIXELS, LCD width 320, LCD height 240 and the FSM state enum from the shared package cam_pkg.
REQ-032 SHALL instantiate one sub-module, cam_input_sync, holding the synchronizers and edge detection for pclk, vsync and href; the FSM and sequencer live in the top.

Verification
REQ-033 SHALL cover one 4x2-pixel frame with bytes 0xF8,0x00,... -> w_data 0xF800 at index 0, indices 0..7 in order, one frame_done.
REQ-034 SHALL cover pclk faster than 2*STROBE_LEN clks/pixel -> overrun=1, later pixels at correct indices, index still reaches 8.
REQ-035 SHALL cover FRAME_PIXELS+3 pixels in one frame -> last write at index 76799, overflow=1, w_bufferIndex never exceeds 76800.
REQ-036 SHALL cover href dropped after the high byte -> no write, next pixel at the unchanged index.
REQ-037 SHALL cover rst asserted mid-line -> all outputs 0 immediately, no w_en until after the next vsync high then low, first write at index 0.
REQ-038 SHALL cover a second frame after overflow -> flags cleared at the vsync fall, index restarts at 0.
